// File: rtl/piezo_decoder.sv
// Classifies the piezo alert tone (over-speed / steer-enable / battery-low) from measured half-periods and flags both legs high.
// Outputs update two clocks after the input transition; no backpressure, tone_vld simply follows the burst cadence.
module piezo_decoder #(
  parameter int HP_OVR   = 4096,
  parameter int HP_STEER = 16384,
  parameter int HP_BATT  = 32768,
  parameter int TOL      = 512,
  parameter int CONFIRM  = 4,
  parameter int TIMEOUT  = 40000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       piezo,
  input  logic       piezo_n,
  input  logic       clr_flt,
  output logic       tone_vld,
  output logic [1:0] tone_code,
  output logic       tone_new,
  output logic       flt
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int MW = $clog2(CONFIRM + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   meas_t;
  typedef logic [MW-1:0] match_t;
  typedef enum logic [1:0] {IDLE, TRACK, LOCK} state_t;

  localparam cnt_t   CNT_TO  = cnt_t'(TIMEOUT);
  localparam cnt_t   CNT_PRE = cnt_t'(TIMEOUT - 1);
  localparam meas_t  OVR_LO  = meas_t'(HP_OVR - TOL);
  localparam meas_t  OVR_HI  = meas_t'(HP_OVR + TOL);
  localparam meas_t  STR_LO  = meas_t'(HP_STEER - TOL);
  localparam meas_t  STR_HI  = meas_t'(HP_STEER + TOL);
  localparam meas_t  BAT_LO  = meas_t'(HP_BATT - TOL);
  localparam meas_t  BAT_HI  = meas_t'(HP_BATT + TOL);
  localparam match_t MATCH_N = match_t'(CONFIRM);

  // Overlapping windows would make classification ambiguous.
  if ((HP_OVR + TOL >= HP_STEER - TOL) || (HP_STEER + TOL >= HP_BATT - TOL)) begin : g_bad_windows
    $error("piezo_decoder: tone acceptance windows overlap");
  end
  if (TIMEOUT <= HP_BATT + TOL) begin : g_bad_timeout
    $error("piezo_decoder: TIMEOUT must exceed HP_BATT+TOL");
  end

  logic   p_q, p_qq, pn_q, clr_q;
  logic   edg, timeout;
  cnt_t   hp_cnt;
  meas_t  meas;
  logic [1:0] cls;

  state_t     state, state_nxt;
  logic [1:0] cand, cand_nxt, code_nxt;
  match_t     match, match_nxt;
  logic       vld_nxt, new_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= 1'b0;
      p_qq  <= 1'b0;
      pn_q  <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      p_q   <= piezo;
      p_qq  <= p_q;
      pn_q  <= piezo_n;
      clr_q <= clr_flt;
    end
  end

  assign edg     = p_q ^ p_qq;
  assign meas    = {1'b0, hp_cnt} + meas_t'(1);
  assign timeout = !edg && (hp_cnt == CNT_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                hp_cnt <= '0;
    else if (edg)              hp_cnt <= '0;
    else if (hp_cnt != CNT_TO) hp_cnt <= hp_cnt + cnt_t'(1);
  end

  always_comb begin
    cls = 2'b00;
    if (meas >= OVR_LO && meas <= OVR_HI)      cls = 2'b01;
    else if (meas >= STR_LO && meas <= STR_HI) cls = 2'b10;
    else if (meas >= BAT_LO && meas <= BAT_HI) cls = 2'b11;
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    match_nxt = match;
    vld_nxt   = tone_vld;
    code_nxt  = tone_code;
    new_nxt   = 1'b0;
    if (timeout) begin
      state_nxt = IDLE;
      cand_nxt  = 2'b00;
      match_nxt = '0;
      vld_nxt   = 1'b0;
      code_nxt  = 2'b00;
    end else if (edg) begin
      case (state)
        IDLE: begin
          // First edge after silence only starts the interval measurement.
          state_nxt = TRACK;
          cand_nxt  = 2'b00;
          match_nxt = '0;
        end
        TRACK: begin
          if (cls == cand && cls != 2'b00) begin
            match_nxt = match + match_t'(1);
          end else begin
            cand_nxt  = cls;
            match_nxt = match_t'(cls != 2'b00);
          end
          if (match_nxt == MATCH_N) begin
            state_nxt = LOCK;
            vld_nxt   = 1'b1;
            code_nxt  = cand_nxt;
            new_nxt   = 1'b1;
          end
        end
        LOCK: begin
          if (cls != tone_code) begin
            state_nxt = TRACK;
            cand_nxt  = cls;
            match_nxt = match_t'(cls != 2'b00);
            vld_nxt   = 1'b0;
            code_nxt  = 2'b00;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= 2'b00;
      match     <= '0;
      tone_vld  <= 1'b0;
      tone_code <= 2'b00;
      tone_new  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      match     <= match_nxt;
      tone_vld  <= vld_nxt;
      tone_code <= code_nxt;
      tone_new  <= new_nxt;
    end
  end

  // Set wins over a simultaneous clear so a fault is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           flt <= 1'b0;
    else if (p_q && pn_q) flt <= 1'b1;
    else if (clr_q)       flt <= 1'b0;
  end

endmodule

// File: tb/tb_piezo_decoder.sv
// Directed bench for piezo_decoder with scaled tone periods; an interval-level model feeds a scoreboard queue.
module tb_piezo_decoder;

  localparam int HP_OVR   = 64;
  localparam int HP_STEER = 256;
  localparam int HP_BATT  = 512;
  localparam int TOL      = 8;
  localparam int CONFIRM  = 4;
  localparam int TIMEOUT  = 625;

  logic       clk = 1'b0;
  logic       rst_n, piezo, piezo_n, clr_flt;
  logic       tone_vld, tone_new, flt;
  logic [1:0] tone_code;

  piezo_decoder #(
    .HP_OVR(HP_OVR), .HP_STEER(HP_STEER), .HP_BATT(HP_BATT),
    .TOL(TOL), .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .piezo(piezo), .piezo_n(piezo_n), .clr_flt(clr_flt),
    .tone_vld(tone_vld), .tone_code(tone_code), .tone_new(tone_new), .flt(flt)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_TRACK, M_LOCK} mst_t;
  typedef struct packed {logic vld; logic [1:0] code;} exp_t;

  exp_t       sbq[$];
  mst_t       m_st = M_IDLE;
  logic [1:0] m_cand = 2'b00, m_code = 2'b00;
  logic       m_vld = 1'b0;
  int         m_match = 0;
  int         passed = 0, total = 0;
  int         new_cnt = 0, exp_new = 0;
  int         since = 1000;

  always @(posedge clk) if (tone_new === 1'b1) new_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [1:0] cls_of(input int g);
    if (g >= HP_OVR - TOL && g <= HP_OVR + TOL)     return 2'b01;
    if (g >= HP_STEER - TOL && g <= HP_STEER + TOL) return 2'b10;
    if (g >= HP_BATT - TOL && g <= HP_BATT + TOL)   return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_idle();
    m_st = M_IDLE; m_cand = 2'b00; m_match = 0; m_vld = 1'b0; m_code = 2'b00;
  endtask

  task automatic model_edge(input int gap);
    logic [1:0] c;
    exp_t e;
    c = cls_of(gap);
    case (m_st)
      M_IDLE: begin
        m_st = M_TRACK; m_cand = 2'b00; m_match = 0;
      end
      M_TRACK: begin
        if (c == m_cand && c != 2'b00) m_match++;
        else begin
          m_cand = c; m_match = (c != 2'b00) ? 1 : 0;
        end
        if (m_match == CONFIRM) begin
          m_st = M_LOCK; m_vld = 1'b1; m_code = m_cand; exp_new++;
        end
      end
      default: begin
        if (c != m_code) begin
          m_st = M_TRACK; m_cand = c; m_match = (c != 2'b00) ? 1 : 0;
          m_vld = 1'b0; m_code = 2'b00;
        end
      end
    endcase
    e.vld = m_vld;
    e.code = m_code;
    sbq.push_back(e);
  endtask

  // Toggle the drive 'gap' cycles after the previous toggle, then score the result.
  task automatic tog(input int gap, input string tag);
    exp_t e;
    if (gap > since) cyc(gap - since);
    piezo = ~piezo;
    piezo_n = ~piezo;
    model_edge(gap);
    cyc(3);
    since = 3;
    e = sbq.pop_front();
    chk({tag, " vld"}, tone_vld, e.vld);
    chk({tag, " code"}, tone_code, e.code);
  endtask

  task automatic quiet(input string tag);
    cyc(TIMEOUT + 10);
    since += TIMEOUT + 10;
    model_idle();
    chk({tag, " quiet vld"}, tone_vld, 1'b0);
  endtask

  task automatic burst(input int gap, input int edges, input string tag);
    tog(0, tag);
    for (int i = 1; i < edges; i++) tog(gap, tag);
  endtask

  initial begin
    rst_n = 1'b0; piezo = 1'b0; piezo_n = 1'b1; clr_flt = 1'b0;
    #1;
    chk("reset vld", tone_vld, 1'b0);
    chk("reset code", tone_code, 2'b00);
    chk("reset new", tone_new, 1'b0);
    chk("reset flt", flt, 1'b0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Over-speed tone, 12 edges.
    burst(HP_OVR, 12, "t1");
    chk("t1 new pulses", new_cnt, exp_new);
    chk("t1 flt", flt, 1'b0);

    // Steer-enable lock, then switch to battery-low mid-lock.
    burst(HP_STEER, 6, "t2 steer");
    for (int i = 0; i < 6; i++) tog(HP_BATT, "t2 batt");
    chk("t2 new pulses", new_cnt, exp_new);

    // Lock then silence: tone_vld must drop on the cycle hp_cnt saturates.
    quiet("t3");
    burst(HP_OVR, 8, "t3");
    chk("t3 locked", tone_vld, 1'b1);
    cyc(TIMEOUT + 1 - 3);
    chk("t3 pre-timeout vld", tone_vld, 1'b1);
    cyc(1);
    chk("t3 timeout vld", tone_vld, 1'b0);
    chk("t3 timeout code", tone_code, 2'b00);
    since = TIMEOUT + 2;
    model_idle();

    // Window boundaries around the over-speed nominal.
    burst(HP_OVR - TOL - 1, 7, "t4 lo-out");
    quiet("t4a");
    burst(HP_OVR - TOL, 7, "t4 lo-in");
    quiet("t4b");
    burst(HP_OVR + TOL, 7, "t4 hi-in");
    quiet("t4c");
    burst(HP_OVR + TOL + 1, 7, "t4 hi-out");
    chk("t4 new pulses", new_cnt, exp_new);
    quiet("t4d");

    // Alternating tones never confirm.
    tog(0, "t5");
    for (int i = 1; i < 20; i++) tog((i % 2) ? HP_OVR : HP_STEER, "t5");
    chk("t5 new pulses", new_cnt, exp_new);
    quiet("t5");

    // Fault set wins over simultaneous clear; clear alone then works.
    piezo = 1'b1; piezo_n = 1'b1; clr_flt = 1'b1;
    cyc(1);
    chk("t6 flt pre", flt, 1'b0);
    piezo = 1'b0; piezo_n = 1'b1;
    cyc(1);
    chk("t6 flt set priority", flt, 1'b1);
    clr_flt = 1'b0;
    cyc(1);
    chk("t6 flt cleared", flt, 1'b0);
    quiet("t6");

    // Async reset while locked with flt set.
    burst(HP_OVR, 5, "t7 lock");
    piezo_n = 1'b1;
    cyc(1);
    piezo_n = ~piezo;
    cyc(1);
    chk("t7 flt before reset", flt, 1'b1);
    chk("t7 vld before reset", tone_vld, 1'b1);
    #2;
    rst_n = 1'b0;
    piezo = 1'b0; piezo_n = 1'b1;
    #1;
    chk("t7 rst vld", tone_vld, 1'b0);
    chk("t7 rst code", tone_code, 2'b00);
    chk("t7 rst new", tone_new, 1'b0);
    chk("t7 rst flt", flt, 1'b0);
    cyc(3);
    rst_n = 1'b1;
    model_idle();
    since = 0;
    cyc(2);
    burst(HP_OVR, 5, "t7 relock");
    chk("t7 relock vld", tone_vld, 1'b1);
    chk("final new pulses", new_cnt, exp_new);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
